// File: rtl/note_judge_if.sv
// note_judge_if: player/song inputs, note ROM read bus and HUD/renderer outputs of the hit judge.
//   master: judge side (drives note_addr and the result outputs).
//   slave : environment side (drives song timing, buttons and ROM data).
interface note_judge_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic [15:0]       song_time;
  logic              song_run;
  logic              strum;
  logic [4:0]        fret;
  logic [ADDR_W-1:0] note_addr;
  logic [15:0]       note_time;
  logic [4:0]        note_fret;
  logic              match_en;
  logic [15:0]       match_time;
  logic              miss;
  logic              overstrum;
  logic [15:0]       score;
  logic [7:0]        streak;

  modport master (
    input  song_time, song_run, strum, fret, note_time, note_fret,
    output note_addr, match_en, match_time, miss, overstrum, score, streak
  );

  modport slave (
    output song_time, song_run, strum, fret, note_time, note_fret,
    input  note_addr, match_en, match_time, miss, overstrum, score, streak
  );
endinterface

// File: rtl/note_judge.sv
// note_judge: judges strums against the sorted note list, expires unplayed notes and keeps
// score/streak for the HUD.
//   clk65 : pixel clock
//   reset : synchronous, active-high
//   bus   : note_judge_if.master (song inputs, note ROM bus, match/miss/overstrum pulses,
//           score, streak)
// Optional feature: define NOTE_JUDGE_MULT_EN to scale the per-hit increment by a streak
// multiplier min(1 + streak/10, 4); otherwise every hit adds 10.
module note_judge #(
  parameter int unsigned HIT_WINDOW  = 25,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SEARCH_SPAN = 4
) (
  input logic          clk65,
  input logic          reset,
  note_judge_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWait, StCmp} state_e;
  typedef enum logic {ModeScan, ModeExpire} mode_e;

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [2:0]             k_q, k_d;
  logic [ADDR_W-1:0]      head_q, head_d;
  logic [SEARCH_SPAN-1:0] matched_q, matched_d;
  logic                   pending_q, pending_d;
  logic                   strum_dly_q;
  logic [ADDR_W-1:0]      note_addr_q, note_addr_d;
  logic                   match_en_q, match_en_d;
  logic [15:0]            match_time_q, match_time_d;
  logic                   miss_q, miss_d;
  logic                   overstrum_q, overstrum_d;
  logic [15:0]            score_q, score_d;
  logic [7:0]             streak_q, streak_d;

  logic        strum_edge;
  logic [16:0] nt17, st17, win17, abs_diff, incr, score_sum;
  logic        is_sentinel, in_window, too_early, expired, matched_k, last_k, hit, stop;

  assign strum_edge = bus.strum & ~strum_dly_q & bus.song_run;

  // 17-bit arithmetic so song_time + window never wraps.
  assign nt17        = {1'b0, bus.note_time};
  assign st17        = {1'b0, bus.song_time};
  assign win17       = 17'(HIT_WINDOW);
  assign abs_diff    = (nt17 >= st17) ? (nt17 - st17) : (st17 - nt17);
  assign is_sentinel = (bus.note_time == 16'hFFFF);
  assign in_window   = (abs_diff <= win17);
  assign too_early   = (nt17 > st17 + win17);
  assign expired     = !is_sentinel && (st17 > nt17) && ((st17 - nt17) > win17);
  assign last_k      = (k_q == 3'(SEARCH_SPAN - 1));

  always_comb begin
    matched_k = 1'b0;
    for (int unsigned i = 0; i < SEARCH_SPAN; i++) begin
      if (k_q == 3'(i)) matched_k = matched_q[i];
    end
  end

  // The sentinel is never hittable, even if its time lands inside the window.
  assign hit  = !is_sentinel && in_window && (bus.note_fret == bus.fret) && !matched_k;
  assign stop = is_sentinel || too_early || last_k;

`ifdef NOTE_JUDGE_MULT_EN
  // Multiplier uses the streak before this hit is counted.
  always_comb begin
    if (streak_q < 8'd10)      incr = 17'd10;
    else if (streak_q < 8'd20) incr = 17'd20;
    else if (streak_q < 8'd30) incr = 17'd30;
    else                       incr = 17'd40;
  end
`else
  assign incr = 17'd10;
`endif

  assign score_sum = {1'b0, score_q} + incr;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    k_d          = k_q;
    head_d       = head_q;
    matched_d    = matched_q;
    pending_d    = pending_q;
    note_addr_d  = note_addr_q;
    match_en_d   = 1'b0;
    match_time_d = match_time_q;
    miss_d       = 1'b0;
    overstrum_d  = 1'b0;
    score_d      = score_q;
    streak_d     = streak_q;

    // Edges outside IDLE are parked; a second one while parked is dropped.
    if ((state_q != StIdle) && strum_edge) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        // Any parked strum is consumed here; with song stopped it is simply discarded.
        pending_d = 1'b0;
        if (bus.song_run && (pending_q || strum_edge)) begin
          k_d         = 3'd0;
          note_addr_d = head_q;
          mode_d      = ModeScan;
          state_d     = StWait;
        end else if (bus.song_run) begin
          note_addr_d = head_q;
          mode_d      = ModeExpire;
          state_d     = StWait;
        end
      end
      StWait: state_d = StCmp;
      StCmp: begin
        state_d = StIdle;
        if (mode_q == ModeExpire) begin
          if (expired) begin
            head_d    = head_q + ADDR_W'(1);
            matched_d = matched_q >> 1;
            if (!matched_q[0]) begin
              miss_d   = 1'b1;
              streak_d = 8'd0;
            end
          end
        end else if (hit) begin
          for (int unsigned i = 0; i < SEARCH_SPAN; i++) begin
            if (k_q == 3'(i)) matched_d[i] = 1'b1;
          end
          match_en_d   = 1'b1;
          match_time_d = bus.note_time;
          streak_d     = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
          score_d      = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end else if (stop) begin
          overstrum_d = 1'b1;
          streak_d    = 8'd0;
        end else begin
          k_d         = k_q + 3'd1;
          note_addr_d = head_q + ADDR_W'(k_q) + ADDR_W'(1);
          state_d     = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk65) begin
    if (reset) begin
      state_q      <= StIdle;
      mode_q       <= ModeScan;
      k_q          <= 3'd0;
      head_q       <= '0;
      matched_q    <= '0;
      pending_q    <= 1'b0;
      strum_dly_q  <= 1'b0;
      note_addr_q  <= '0;
      match_en_q   <= 1'b0;
      match_time_q <= 16'd0;
      miss_q       <= 1'b0;
      overstrum_q  <= 1'b0;
      score_q      <= 16'd0;
      streak_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      k_q          <= k_d;
      head_q       <= head_d;
      matched_q    <= matched_d;
      pending_q    <= pending_d;
      strum_dly_q  <= bus.strum;
      note_addr_q  <= note_addr_d;
      match_en_q   <= match_en_d;
      match_time_q <= match_time_d;
      miss_q       <= miss_d;
      overstrum_q  <= overstrum_d;
      score_q      <= score_d;
      streak_q     <= streak_d;
    end
  end

  assign bus.note_addr  = note_addr_q;
  assign bus.match_en   = match_en_q;
  assign bus.match_time = match_time_q;
  assign bus.miss       = miss_q;
  assign bus.overstrum  = overstrum_q;
  assign bus.score      = score_q;
  assign bus.streak     = streak_q;

endmodule

// File: doc/note_judge.md
# note_judge

Hit-judging stage that sits directly upstream of the per-string note renderer. It watches the player's strum and fret buttons against the song's sorted note list and the running `song_time`, and decides whether each strum hits a note. On a hit it issues the one-cycle `match_en` / `match_time` pair that the renderer uses to invert a matched note's sprite. It also flags notes that expire unplayed and maintains score and streak counters for the HUD.

## Interface
Parameters:
- `HIT_WINDOW`, 25: half-width of the hit window in `song_time` ticks (10 ms each).
- `ADDR_W`, 5: note-memory address width.
- `SEARCH_SPAN`, 4: maximum notes examined per strum, counted from `head`; range 1..8.

Ports:
- `clk65`  in  1  system pixel clock.
- `reset`  in  1  synchronous, active-high.
- `song_time`  in  16  current song time, monotonic while `song_run`.
- `song_run`  in  1  song playing; strums and expiry are ignored while low.
- `strum`  in  1  synchronized, debounced strum level.
- `fret`  in  5  synchronized fret-button level vector.
- `note_addr`  out  ADDR_W  registered read address to note_times/note_frets ROMs.
- `note_time`  in  16  ROM time data, valid 1 cycle after `note_addr`; 16'hFFFF marks end of song.
- `note_fret`  in  5  ROM fret data, same timing.
- `match_en`  out  1  one-cycle hit pulse.
- `match_time`  out  16  time of the hit note; held until the next hit.
- `miss`  out  1  one-cycle pulse when a note expires unmatched.
- `overstrum`  out  1  one-cycle pulse when a strum hits nothing.
- `score`  out  16  saturating at 16'hFFFF.
- `streak`  out  8  consecutive hits, saturating at 255.

## Operation
- `head` (ADDR_W bits) indexes the oldest unexpired note.
- `matched[SEARCH_SPAN-1:0]` flags notes head+k that are already hit. On each head advance the vector shifts right and zero-fills its top bit.
- Strum edge: `strum & ~strum_d`, detected only while `song_run` is high. An edge sets `pending`. Only one `pending` is held; further edges while it is set are dropped.
- FSM states are IDLE, WAIT and CMP. A `mode` register selects SCAN or EXPIRE, and `k` (3 bits) is the candidate offset.
  - IDLE with `pending`: clear `pending`, set k=0, `note_addr`=head, mode=SCAN, go to WAIT.
  - IDLE with no pending and `song_run`: `note_addr`=head, mode=EXPIRE, go to WAIT.
  - Otherwise IDLE stays in IDLE.
  - WAIT always goes to CMP.
  - CMP in EXPIRE mode: if `note_time` is not FFFF and song_time − note_time > HIT_WINDOW (with song_time > note_time), then head++. If ~matched[0], also pulse `miss` and set streak=0. Return to IDLE.
  - CMP in SCAN mode, compare using 17-bit unsigned differences:
    - Hit: |note_time − song_time| ≤ HIT_WINDOW, note_fret == fret, and ~matched[k]. Set matched[k], pulse `match_en`, set match_time=note_time, increment streak, add to score. Go to IDLE.
    - Stop: note_time == FFFF, note_time > song_time+HIT_WINDOW, or k == SEARCH_SPAN−1. Pulse `overstrum`, set streak=0, go to IDLE.
    - Otherwise: k++, `note_addr`=head+k+1, go to WAIT.
- Score increment is 10 per hit. Score saturates at FFFF and never wraps.
- Address arithmetic is modulo 2^ADDR_W. Head never advances past a sentinel note.

## Timing
- Reset values: `note_addr`=0, `match_en`=0, `match_time`=0, `miss`=0, `overstrum`=0, `score`=0, `streak`=0. Internally head=0, matched=0, pending=0, state IDLE, strum_d=0.
- Reset is honoured in any state; it aborts a scan with no pulse.
- ROM read latency is 1 cycle, so each candidate costs 2 cycles (WAIT, CMP).
- Edge seen in IDLE at cycle 0: a hit on candidate k pulses `match_en` in cycle 3+2k. `overstrum` follows the same formula for the terminating k.
- An edge arriving during an EXPIRE pass waits at most 2 extra cycles.
- The pulse outputs (`match_en`, `miss`, `overstrum`) are registered and mutually exclusive in any cycle.
- `song_run` falling mid-scan: the scan completes normally. New edges are ignored and `pending` is cleared on the next IDLE.

## Configuration
- `NOTE_JUDGE_MULT_EN` defined: the hit increment is 10×M, where M = min(1 + streak/10, 4). The streak used is the value before this hit's increment.
- `NOTE_JUDGE_MULT_EN` undefined: the increment is always 10. The multiplier logic is absent.

## Test plan
- Note {t=100, fret=00100}; strum at song_time=110 with fret=00100 -> `match_en` pulse exactly 3 cycles after the edge, match_time=100, score=10, streak=1.
- Same note, fret=00010 at 110 -> `overstrum` pulse, streak=0, no `match_en`.
- Notes at 100 and 102 (same fret); strum twice at 101 -> first strum hits 100 (k=0), second hits 102 (k=1, pulse at cycle 5). The first note is never re-hit.
- Note at 100 unplayed; advance song_time to 126 -> one `miss` pulse, head=1, streak=0. A matched note expiring gives no `miss`.
- With `NOTE_JUDGE_MULT_EN`: 25 consecutive hits -> score=10·10+10·20+5·30=450. Without the macro -> 250. Score preset near FFFF saturates.
- Sentinel FFFF at head with song_time=FFF0 -> head holds; strum gives `overstrum`. Reset mid-scan clears all outputs with no pulse.
